vram_arbiter: RTL

//  Shares the single 16-bit-address / 8-bit-data VRAM port among three requesters:

---
 rtl/vram_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous VRAM port among bg, spr and cpu (bg > spr > cpu).
// Define VRAM_ARB_STARVE_EN to promote a starved cpu requester above bg and spr.
module vram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 15,
    parameter logic [15:0] MEM_TOP      = 16'h2BFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bg_req,
    input  logic [15:0] bg_addr,
    output logic        bg_gnt,
    output logic        bg_rvalid,
    input  logic        spr_req,
    input  logic [15:0] spr_addr,
    output logic        spr_gnt,
    output logic        spr_rvalid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic        cpu_err,
    output logic [7:0]  rdata,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_BG   = 2'd1,
        WIN_SPR  = 2'd2,
        WIN_CPU  = 2'd3
    } win_e;

    typedef struct packed {
        logic bg;
        logic spr;
        logic cpu;
        logic rej;
    } tag_t;

    win_e        win_s;
    logic        cpu_first_s;
    logic        cpu_rej_s;
    tag_t        tag_in_s;
    logic [15:0] nxt_addr_s;
    logic        nxt_we_s;
    logic [7:0]  nxt_wdata_s;
    logic        nxt_err_s;

    logic [15:0] mem_addr_r;
    logic        mem_we_r;
    logic [7:0]  mem_wdata_r;
    logic        cpu_err_r;
    tag_t        stage1_r;
    tag_t        stage2_r;

`ifdef VRAM_ARB_STARVE_EN
    localparam logic [7:0] LIMIT8 = 8'(STARVE_LIMIT);
    logic [7:0] wait_cnt_r;

    // Count cycles the cpu is refused; saturate at the limit, clear on grant or idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r <= 8'd0;
        end else if (cpu_req && !cpu_gnt) begin
            if (wait_cnt_r >= LIMIT8) begin
                wait_cnt_r <= LIMIT8;
            end else begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end
        end else begin
            wait_cnt_r <= 8'd0;
        end
    end

    assign cpu_first_s = (wait_cnt_r == LIMIT8);
`else
    assign cpu_first_s = 1'b0;
`endif

    assign cpu_rej_s = (cpu_addr > MEM_TOP);

    // Pick the single winner for this cycle.
    always_comb begin
        win_s = WIN_NONE;
        if (cpu_req && cpu_first_s) begin
            win_s = WIN_CPU;
        end else if (bg_req) begin
            win_s = WIN_BG;
        end else if (spr_req) begin
            win_s = WIN_SPR;
        end else if (cpu_req) begin
            win_s = WIN_CPU;
        end else begin
            win_s = WIN_NONE;
        end
    end

    assign bg_gnt  = (win_s == WIN_BG);
    assign spr_gnt = (win_s == WIN_SPR);
    assign cpu_gnt = (win_s == WIN_CPU);

    // Next VRAM command and read tag from the winner; a rejected cpu access leaves the port untouched.
    always_comb begin
        tag_in_s    = '0;
        nxt_addr_s  = mem_addr_r;
        nxt_we_s    = 1'b0;
        nxt_wdata_s = mem_wdata_r;
        nxt_err_s   = 1'b0;
        case (win_s)
            WIN_BG: begin
                nxt_addr_s = bg_addr;
                tag_in_s.bg = 1'b1;
            end
            WIN_SPR: begin
                nxt_addr_s = spr_addr;
                tag_in_s.spr = 1'b1;
            end
            WIN_CPU: begin
                if (cpu_rej_s) begin
                    nxt_err_s    = 1'b1;
                    tag_in_s.cpu = !cpu_we;
                    tag_in_s.rej = !cpu_we;
                end else begin
                    nxt_addr_s   = cpu_addr;
                    nxt_we_s     = cpu_we;
                    tag_in_s.cpu = !cpu_we;
                    if (cpu_we) begin
                        nxt_wdata_s = cpu_wdata;
                    end else begin
                        nxt_wdata_s = mem_wdata_r;
                    end
                end
            end
            default: begin
                nxt_addr_s = mem_addr_r;
            end
        endcase
    end

    // VRAM command register and error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr_r  <= 16'h0000;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= 8'h00;
            cpu_err_r   <= 1'b0;
        end else begin
            mem_addr_r  <= nxt_addr_s;
            mem_we_r    <= nxt_we_s;
            mem_wdata_r <= nxt_wdata_s;
            cpu_err_r   <= nxt_err_s;
        end
    end

    // Two-stage tag pipeline lining read ownership up with mem_rdata.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage1_r <= '0;
            stage2_r <= '0;
        end else begin
            stage1_r <= tag_in_s;
            stage2_r <= stage1_r;
        end
    end

    assign mem_addr   = mem_addr_r;
    assign mem_we     = mem_we_r;
    assign mem_wdata  = mem_wdata_r;
    assign cpu_err    = cpu_err_r;
    assign bg_rvalid  = stage2_r.bg;
    assign spr_rvalid = stage2_r.spr;
    assign cpu_rvalid = stage2_r.cpu;
    assign rdata      = stage2_r.rej ? 8'h00 : mem_rdata;

endmodule
